// File: rtl/inst_fetcher_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | inst_fetcher_pkg                                                 |
// | Shared widths, strobe levels and fetch FSM encodings.            |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package inst_fetcher_pkg;

  localparam int INSTRUCTION_WIDTH = 32;
  localparam int ADDRESS_WIDTH     = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [ADDRESS_WIDTH-1:0] NULL = '0;

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_MEM = 1'b1;

  function automatic logic [ADDRESS_WIDTH-1:0] next_pc(input logic [ADDRESS_WIDTH-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetcher_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | inst_fetcher_if                                                  |
// | Instruction-queue push port and memory-controller fetch port.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface inst_fetcher_if;
  import inst_fetcher_pkg::*;

  logic                         iq_rdy_in;
  logic                         iq_en_out;
  logic [INSTRUCTION_WIDTH-1:0] iq_inst_out;
  logic [ADDRESS_WIDTH-1:0]     iq_pc_out;

  logic                         mem_req_out;
  logic [ADDRESS_WIDTH-1:0]     mem_addr_out;
  logic                         mem_done_in;
  logic [INSTRUCTION_WIDTH-1:0] mem_inst_in;

  modport master (
    input  iq_rdy_in,
    output iq_en_out,
    output iq_inst_out,
    output iq_pc_out,
    output mem_req_out,
    output mem_addr_out,
    input  mem_done_in,
    input  mem_inst_in
  );

  modport slave (
    output iq_rdy_in,
    input  iq_en_out,
    input  iq_inst_out,
    input  iq_pc_out,
    input  mem_req_out,
    input  mem_addr_out,
    output mem_done_in,
    output mem_inst_in
  );

endinterface
`default_nettype wire

// File: rtl/inst_fetcher_icache_dm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | icache_dm                                                        |
// | Direct-mapped one-word-per-line cache, combinational lookup.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module icache_dm
  import inst_fetcher_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  wire logic                         clk_in,
  input  wire logic                         rst_in,
  input  wire logic [ADDRESS_WIDTH-3:0]     i_rd_waddr,
  output logic                              o_hit,
  output logic [INSTRUCTION_WIDTH-1:0]      o_rd_word,
  input  wire logic                         i_wr_en,
  input  wire logic [ADDRESS_WIDTH-3:0]     i_wr_waddr,
  input  wire logic [INSTRUCTION_WIDTH-1:0] i_wr_word
);

  localparam int LINES = 2 ** IDX_W;
  localparam int TAG_W = ADDRESS_WIDTH - 2 - IDX_W;

  logic [LINES-1:0]             r_valid;
  logic [TAG_W-1:0]             r_tag  [LINES];
  logic [INSTRUCTION_WIDTH-1:0] r_data [LINES];

  logic [IDX_W-1:0] w_rd_idx;
  logic [TAG_W-1:0] w_rd_tag;
  logic [IDX_W-1:0] w_wr_idx;
  logic [TAG_W-1:0] w_wr_tag;

  assign w_rd_idx = i_rd_waddr[IDX_W-1:0];
  assign w_rd_tag = i_rd_waddr[ADDRESS_WIDTH-3:IDX_W];
  assign w_wr_idx = i_wr_waddr[IDX_W-1:0];
  assign w_wr_tag = i_wr_waddr[ADDRESS_WIDTH-3:IDX_W];

  assign o_hit     = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign o_rd_word = r_data[w_rd_idx];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[w_wr_idx] <= ENABLE;
    end
  end

  // Tag and data need no reset: they are qualified by r_valid.
  always_ff @(posedge clk_in) begin
    if (i_wr_en) begin
      r_tag[w_wr_idx]  <= w_wr_tag;
      r_data[w_wr_idx] <= i_wr_word;
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_fetcher.sv
`default_nettype none
// +------------------------------------------------------------------+
// | inst_fetcher                                                     |
// | Fetch FSM: PC+4 prediction, icache lookup, miss fill, IQ push.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int                       ICACHE_IDX_W = 6,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC     = 32'h0
) (
  input  wire logic                     clk_in,
  input  wire logic                     rst_in,
  input  wire logic                     rdy_in,
  input  wire logic                     rob_flush_in,
  input  wire logic [ADDRESS_WIDTH-1:0] rob_target_pc_in,
  inst_fetcher_if.master                fetch_bus
);

  logic [ADDRESS_WIDTH-1:0]     r_pc;
  logic [0:0]                   r_state;
  logic                         r_discard;
  logic                         r_iq_en;
  logic [INSTRUCTION_WIDTH-1:0] r_iq_inst;
  logic [ADDRESS_WIDTH-1:0]     r_iq_pc;
  logic                         r_mem_req;
  logic [ADDRESS_WIDTH-1:0]     r_mem_addr;

  logic                         w_hit;
  logic [INSTRUCTION_WIDTH-1:0] w_word;
  logic                         w_fill;

  // A completion only counts while the controller is not stalled.
  assign w_fill = rdy_in && (r_state == WAIT_MEM) && fetch_bus.mem_done_in;

  icache_dm #(
    .IDX_W (ICACHE_IDX_W)
  ) u_icache (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_rd_waddr (r_pc[ADDRESS_WIDTH-1:2]),
    .o_hit      (w_hit),
    .o_rd_word  (w_word),
    .i_wr_en    (w_fill),
    .i_wr_waddr (r_mem_addr[ADDRESS_WIDTH-1:2]),
    .i_wr_word  (fetch_bus.mem_inst_in)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_pc       <= RESET_PC;
      r_state    <= IDLE;
      r_discard  <= DISABLE;
      r_iq_en    <= DISABLE;
      r_iq_inst  <= NULL;
      r_iq_pc    <= NULL;
      r_mem_req  <= DISABLE;
      r_mem_addr <= NULL;
    end else begin
      r_iq_en <= DISABLE;
      if (rdy_in) begin
        case (r_state)
          IDLE: begin
            if (rob_flush_in) begin
              r_pc <= rob_target_pc_in;
            end else if (w_hit) begin
              if (fetch_bus.iq_rdy_in) begin
                r_iq_en   <= ENABLE;
                r_iq_inst <= w_word;
                r_iq_pc   <= r_pc;
                r_pc      <= next_pc(r_pc);
              end
            end else begin
              // Misses prefetch into the cache even when the queue is full.
              r_mem_req  <= ENABLE;
              r_mem_addr <= r_pc;
              r_state    <= WAIT_MEM;
            end
          end
          WAIT_MEM: begin
            if (fetch_bus.mem_done_in) begin
              r_mem_req <= DISABLE;
              r_discard <= DISABLE;
              r_state   <= IDLE;
            end else if (rob_flush_in) begin
              r_discard <= ENABLE;
            end
            if (rob_flush_in) begin
              r_pc <= rob_target_pc_in;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign fetch_bus.iq_en_out    = r_iq_en;
  assign fetch_bus.iq_inst_out  = r_iq_inst;
  assign fetch_bus.iq_pc_out    = r_iq_pc;
  assign fetch_bus.mem_req_out  = r_mem_req;
  assign fetch_bus.mem_addr_out = r_mem_addr;

  // A stale in-flight fetch can only exist while the request is outstanding.
  a_discard_in_wait: assert property (@(posedge clk_in) disable iff (rst_in)
    r_discard |-> (r_state == WAIT_MEM));

endmodule
`default_nettype wire

// File: tb/tb_inst_fetcher.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_inst_fetcher                                                  |
// | Scoreboard bench: directed scenarios then randomized traffic.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_inst_fetcher;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic [31:0] target;

  int   checks   = 0;
  int   failures = 0;
  int   n_push   = 0;
  int   lat      = 3;
  bit   mem_hold = 1'b0;
  exp_t exp_q[$];

  inst_fetcher_if bus ();

  inst_fetcher #(
    .ICACHE_IDX_W (6),
    .RESET_PC     (32'h0)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .rdy_in           (rdy),
    .rob_flush_in     (flush),
    .rob_target_pc_in (target),
    .fetch_bus        (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference instruction stream: consecutive words from a redirect point.
  task automatic refill(input logic [31:0] t);
    exp_q.delete();
    for (int i = 0; i < 1024; i++) begin
      exp_t e;
      e.pc   = t + 32'(4 * i);
      e.inst = mem_word(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst && flush && rdy) refill(target);
    #2;
  endtask

  task automatic hold_flush(input logic [31:0] t);
    int n = 0;
    flush  = 1'b1;
    target = t;
    do begin
      tick();
      n++;
    end while (bus.mem_req_out && n < 40);
    chk(!bus.mem_req_out, "flush_settle", 32'(bus.mem_req_out), 32'h0);
    flush = 1'b0;
  endtask

  task automatic wait_req_low();
    int n = 0;
    do begin
      tick();
      n++;
    end while (bus.mem_req_out && n < 30);
    chk(!bus.mem_req_out, "req_done_timeout", 32'(bus.mem_req_out), 32'h0);
  endtask

  // Memory controller model: answers after lat cycles, honours rdy stalls.
  initial begin
    int waitc = 0;
    logic r_rdy;
    bus.mem_done_in = 1'b0;
    bus.mem_inst_in = 32'h0;
    forever begin
      @(posedge clk);
      r_rdy = rdy;
      #1;
      if (rst) begin
        bus.mem_done_in = 1'b0;
        waitc = 0;
      end else if (bus.mem_done_in && r_rdy) begin
        bus.mem_done_in = 1'b0;
        waitc = 0;
      end else begin
        bus.mem_done_in = 1'b0;
        if (bus.mem_req_out && !mem_hold) begin
          if (waitc >= lat) begin
            bus.mem_done_in = 1'b1;
            bus.mem_inst_in = mem_word(bus.mem_addr_out);
          end else begin
            waitc++;
          end
        end
      end
    end
  end

  // Monitor: every push is popped against the reference stream.
  initial begin
    bit          rst_s, rdy_s, iqr_s, fl_s, prev_req;
    logic [31:0] prev_addr;
    exp_t        e;
    prev_req  = 1'b0;
    prev_addr = 32'h0;
    forever begin
      @(posedge clk);
      rst_s = rst; rdy_s = rdy; iqr_s = bus.iq_rdy_in; fl_s = flush;
      #1;
      if (rst_s) begin
        prev_req = 1'b0;
      end else begin
        if (bus.iq_en_out) begin
          n_push++;
          chk(rdy_s && iqr_s && !fl_s, "push_allowed", bus.iq_pc_out, 32'h0);
          chk(exp_q.size() != 0, "push_unexpected", bus.iq_pc_out, 32'h0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(bus.iq_pc_out == e.pc, "push_pc", bus.iq_pc_out, e.pc);
            chk(bus.iq_inst_out == e.inst, "push_inst", bus.iq_inst_out, e.inst);
          end
        end
        if (!rdy_s) chk(bus.mem_req_out == prev_req, "stall_req", 32'(bus.mem_req_out), 32'(prev_req));
        if (prev_req && bus.mem_req_out)
          chk(bus.mem_addr_out == prev_addr, "req_addr_stable", bus.mem_addr_out, prev_addr);
        if (!prev_req && bus.mem_req_out && exp_q.size() != 0)
          chk(bus.mem_addr_out == exp_q[0].pc, "req_addr", bus.mem_addr_out, exp_q[0].pc);
        prev_req  = bus.mem_req_out;
        prev_addr = bus.mem_addr_out;
      end
    end
  end

  initial begin
    int n;
    int pushes_before;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; target = 32'h0;
    bus.iq_rdy_in = 1'b1;
    #3;
    chk(!bus.iq_en_out, "rst_iq_en", 32'(bus.iq_en_out), 32'h0);
    chk(bus.iq_inst_out == 32'h0, "rst_iq_inst", bus.iq_inst_out, 32'h0);
    chk(bus.iq_pc_out == 32'h0, "rst_iq_pc", bus.iq_pc_out, 32'h0);
    chk(!bus.mem_req_out, "rst_mem_req", 32'(bus.mem_req_out), 32'h0);
    chk(bus.mem_addr_out == 32'h0, "rst_mem_addr", bus.mem_addr_out, 32'h0);

    // Cold start
    @(posedge clk); #2;
    rst = 1'b0;
    refill(32'h0);
    tick();
    chk(bus.mem_req_out && bus.mem_addr_out == 32'h0, "cold_req", bus.mem_addr_out, 32'h0);
    n = 0;
    do begin tick(); n++; end while (!bus.mem_done_in && n < 20);
    chk(bus.mem_done_in, "cold_done_timeout", 32'(bus.mem_done_in), 32'h1);
    tick();
    chk(!bus.iq_en_out, "cold_no_early_push", 32'(bus.iq_en_out), 32'h0);
    tick();
    chk(bus.iq_en_out && bus.iq_pc_out == 32'h0, "cold_push_pc", bus.iq_pc_out, 32'h0);
    chk(bus.iq_inst_out == 32'h13, "cold_push_inst", bus.iq_inst_out, 32'h13);
    tick();
    chk(bus.mem_req_out && bus.mem_addr_out == 32'h4, "cold_next_req", bus.mem_addr_out, 32'h4);

    // Warm loop
    hold_flush(32'h0);
    n = 0;
    do begin tick(); n++; end while (!(bus.iq_en_out && bus.iq_pc_out == 32'hC) && n < 100);
    chk(bus.iq_en_out && bus.iq_pc_out == 32'hC, "preload_timeout", bus.iq_pc_out, 32'hC);
    hold_flush(32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk(bus.iq_en_out && bus.iq_pc_out == 32'(4 * i), "warm_push", bus.iq_pc_out, 32'(4 * i));
      chk(!bus.mem_req_out, "warm_no_req", 32'(bus.mem_req_out), 32'h0);
    end

    // Backpressure at pc 0x8
    hold_flush(32'h0);
    tick();
    tick();
    chk(bus.iq_en_out && bus.iq_pc_out == 32'h4, "bp_push4", bus.iq_pc_out, 32'h4);
    bus.iq_rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk(!bus.iq_en_out && !bus.mem_req_out, "bp_hold", 32'(bus.iq_en_out), 32'h0);
    end
    bus.iq_rdy_in = 1'b1;
    tick();
    chk(bus.iq_en_out && bus.iq_pc_out == 32'h8, "bp_resume", bus.iq_pc_out, 32'h8);

    // Flush during miss
    hold_flush(32'h40);
    mem_hold = 1'b1;
    tick();
    chk(bus.mem_req_out && bus.mem_addr_out == 32'h40, "miss40_req", bus.mem_addr_out, 32'h40);
    flush = 1'b1; target = 32'h100;
    tick();
    flush = 1'b0;
    mem_hold = 1'b0;
    wait_req_low();
    tick();
    chk(bus.mem_req_out && bus.mem_addr_out == 32'h100, "redirect_req", bus.mem_addr_out, 32'h100);
    wait_req_low();

    // Aliasing: 0x0 was evicted by 0x100
    hold_flush(32'h0);
    tick();
    chk(bus.mem_req_out && bus.mem_addr_out == 32'h0, "alias_refetch", bus.mem_addr_out, 32'h0);
    hold_flush(32'h40);
    tick();
    chk(bus.iq_en_out && bus.iq_pc_out == 32'h40 && !bus.mem_req_out, "discarded_fill_kept",
        bus.iq_pc_out, 32'h40);

    // Stall while done pulses, then async reset mid-wait
    hold_flush(32'h200);
    mem_hold = 1'b1;
    tick();
    chk(bus.mem_req_out && bus.mem_addr_out == 32'h200, "stall_req", bus.mem_addr_out, 32'h200);
    rdy = 1'b0; lat = 0; mem_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk(bus.mem_req_out && !bus.iq_en_out, "stall_wait", 32'(bus.mem_req_out), 32'h1);
    end
    mem_hold = 1'b1;
    rst = 1'b1;
    #1;
    chk(!bus.mem_req_out && bus.mem_addr_out == 32'h0, "async_rst_req", 32'(bus.mem_req_out), 32'h0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0; rdy = 1'b1; mem_hold = 1'b0; lat = 2;
    refill(32'h0);
    tick();
    chk(bus.mem_req_out && bus.mem_addr_out == 32'h0, "rst_valid_clear", bus.mem_addr_out, 32'h0);

    // Randomized traffic
    pushes_before = n_push;
    for (int i = 0; i < 3000; i++) begin
      rdy           = ($urandom_range(0, 9) != 0);
      bus.iq_rdy_in = ($urandom_range(0, 9) < 7);
      flush         = ($urandom_range(0, 19) == 0);
      target        = 32'($urandom_range(0, 255)) << 2;
      lat           = int'($urandom_range(0, 4));
      tick();
    end
    flush = 1'b0; rdy = 1'b1;
    repeat (8) tick();
    chk(n_push - pushes_before > 100, "random_progress", 32'(n_push - pushes_before), 32'd100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
